fetch_unit: RTL and testbench

Instruction fetch stage of the MIPS-subset core, directly upstream of `decoder`. Holds the program counter, issues word reads to instruction memory over a req/ack handshake, and presents the fetched word to `decoder` with a valid/stall handshake. It computes the next PC from the control fields that `decoder` and the ALU return for the instruction currently held: `pcSrcCtrl`, `jAddr`, `imm` and `bneCtrl` from `decoder`, and the zero flag from the ALU. It also counts retired instructions.

---
 rtl/mips_pkg.sv | 16 +
 rtl/fetch_unit_next_pc.sv | 48 ++++
 rtl/fetch_unit.sv | 112 +++++++++++
 tb/tb_fetch_unit.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS-subset core.
// Holds the pcSrc encodings (must match decoder) and the fetch FSM state type.
package mips_pkg;

    localparam logic [1:0] PC_SEQ    = 2'd0;
    localparam logic [1:0] PC_JUMP   = 2'd1;
    localparam logic [1:0] PC_JR     = 2'd2;
    localparam logic [1:0] PC_BRANCH = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit_next_pc.sv
// next_pc: combinational next-PC selection for the fetch unit.
// Ports:
//   instr_pc  in  32  PC of the instruction being retired
//   pcSrcCtrl in   2  0 seq, 1 jump, 2 jump-register, 3 branch
//   jAddr     in  26  jump target field
//   imm       in  32  sign-extended branch offset (in words)
//   jrTarget  in  32  rs value for JR
//   aluZero   in   1  ALU zero flag
//   bneCtrl   in   1  inverts the branch condition (BNE)
//   next_pc   out 32  selected next PC
module next_pc
    import mips_pkg::*;
(
    input  logic [31:0] instr_pc,
    input  logic [1:0]  pcSrcCtrl,
    input  logic [25:0] jAddr,
    input  logic [31:0] imm,
    input  logic [31:0] jrTarget,
    input  logic        aluZero,
    input  logic        bneCtrl,
    output logic [31:0] next_pc
);

    logic [31:0] p4_s;
    logic [31:0] imm_sh_s;

    assign p4_s     = instr_pc + 32'd4;
    assign imm_sh_s = imm << 2;

    // Target selection; JR low bits are masked rather than trapped.
    always_comb begin
        next_pc = p4_s;
        case (pcSrcCtrl)
            PC_SEQ:    next_pc = p4_s;
            PC_JUMP:   next_pc = {p4_s[31:28], jAddr, 2'b00};
            PC_JR:     next_pc = jrTarget & 32'hFFFF_FFFC;
            PC_BRANCH: begin
                if (aluZero ^ bneCtrl) begin
                    next_pc = p4_s + imm_sh_s;
                end else begin
                    next_pc = p4_s;
                end
            end
            default:   next_pc = p4_s;
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage. Holds the PC, reads instruction memory
// over req/ack, presents the word to decoder with valid/stall, computes the
// next PC on accept and counts accepted instructions.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   imem_req/imem_addr (out)        memory read request, address = pc
//   imem_ack/imem_rdata (in)        memory read completion and data
//   instr/instr_valid/instr_pc (out) held instruction, its valid flag and PC
//   stall (in)                      downstream holds the instruction
//   pcSrcCtrl,jAddr,imm,jrTarget,aluZero,bneCtrl (in)  next-PC controls
//   instr_count (out)               accepted-instruction counter (wraps)
module fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] instr_pc,
    input  logic        stall,
    input  logic [1:0]  pcSrcCtrl,
    input  logic [25:0] jAddr,
    input  logic [31:0] imm,
    input  logic [31:0] jrTarget,
    input  logic        aluZero,
    input  logic        bneCtrl,
    output logic [31:0] instr_count
);

    fetch_state_e state_r;
    logic [31:0]  pc_r;
    logic [31:0]  instr_r;
    logic [31:0]  instr_pc_r;
    logic         instr_valid_r;
    logic         imem_req_r;
    logic [31:0]  count_r;
    logic [31:0]  next_pc_s;

    next_pc u_next_pc (
        .instr_pc  (instr_pc_r),
        .pcSrcCtrl (pcSrcCtrl),
        .jAddr     (jAddr),
        .imm       (imm),
        .jrTarget  (jrTarget),
        .aluZero   (aluZero),
        .bneCtrl   (bneCtrl),
        .next_pc   (next_pc_s)
    );

    // Fetch FSM with PC, instruction register and retire counter.
    // Request and valid are registered alongside the state so they change
    // exactly on state transitions; acks outside REQ fall into no branch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            pc_r          <= RESET_PC;
            instr_r       <= 32'd0;
            instr_pc_r    <= 32'd0;
            instr_valid_r <= 1'b0;
            imem_req_r    <= 1'b0;
            count_r       <= 32'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    imem_req_r <= 1'b1;
                    state_r    <= ST_REQ;
                end
                ST_REQ: begin
                    if (imem_ack) begin
                        instr_r       <= imem_rdata;
                        instr_pc_r    <= pc_r;
                        instr_valid_r <= 1'b1;
                        imem_req_r    <= 1'b0;
                        state_r       <= ST_HOLD;
                    end else begin
                        state_r <= ST_REQ;
                    end
                end
                ST_HOLD: begin
                    if (instr_valid_r && !stall) begin
                        pc_r          <= next_pc_s;
                        count_r       <= count_r + 32'd1;
                        instr_valid_r <= 1'b0;
                        imem_req_r    <= 1'b1;
                        state_r       <= ST_REQ;
                    end else begin
                        state_r <= ST_HOLD;
                    end
                end
                default: begin
                    instr_valid_r <= 1'b0;
                    imem_req_r    <= 1'b0;
                    state_r       <= ST_IDLE;
                end
            endcase
        end
    end

    assign imem_req    = imem_req_r;
    assign imem_addr   = pc_r;
    assign instr       = instr_r;
    assign instr_valid = instr_valid_r;
    assign instr_pc    = instr_pc_r;
    assign instr_count = count_r;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected fetch addresses are queued when
// the accepting controls are driven and popped when the next request appears.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] instr_pc;
    logic        stall;
    logic [1:0]  pcSrcCtrl;
    logic [25:0] jAddr;
    logic [31:0] imm;
    logic [31:0] jrTarget;
    logic        aluZero;
    logic        bneCtrl;
    logic [31:0] instr_count;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_addr_q[$];
    logic [31:0] cur_addr;
    logic [31:0] exp_count;

    fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_pc    (instr_pc),
        .stall       (stall),
        .pcSrcCtrl   (pcSrcCtrl),
        .jAddr       (jAddr),
        .imm         (imm),
        .jrTarget    (jrTarget),
        .aluZero     (aluZero),
        .bneCtrl     (bneCtrl),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
        end
    endtask

    // Wait (bounded) for a request, then pop the scoreboard and compare address.
    task automatic wait_req();
        int n = 0;
        while (imem_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("req_seen", {31'd0, imem_req}, 32'd1);
        if (exp_addr_q.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
            cur_addr = 32'hXXXX_XXXX;
        end else begin
            cur_addr = exp_addr_q.pop_front();
            chk("imem_addr", imem_addr, cur_addr);
        end
    endtask

    // One fetch with memory latency lat (>=1 cycles in REQ before the ack edge).
    task automatic fetch(input int lat, input logic [31:0] data);
        wait_req();
        for (int i = 1; i < lat; i++) begin
            @(negedge clk);
            chk("req_held", {31'd0, imem_req}, 32'd1);
            chk("addr_held", imem_addr, cur_addr);
        end
        imem_ack   = 1'b1;
        imem_rdata = data;
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        chk("valid_up", {31'd0, instr_valid}, 32'd1);
        chk("instr", instr, data);
        chk("instr_pc", instr_pc, cur_addr);
        chk("req_down", {31'd0, imem_req}, 32'd0);
    endtask

    // Accept the held instruction with the given controls; queue the expected target.
    task automatic accept(input logic [1:0] src, input logic [25:0] ja, input logic [31:0] im,
                          input logic [31:0] jr, input logic az, input logic bn,
                          input logic [31:0] exp_next);
        pcSrcCtrl = src; jAddr = ja; imm = im; jrTarget = jr; aluZero = az; bneCtrl = bn;
        stall = 1'b0;
        exp_addr_q.push_back(exp_next);
        exp_count = exp_count + 32'd1;
        @(negedge clk);
        stall     = 1'b1;
        pcSrcCtrl = 2'($urandom); jAddr = 26'($urandom); imm = $urandom;
        jrTarget  = $urandom; aluZero = 1'($urandom); bneCtrl = 1'($urandom);
        chk("valid_drop", {31'd0, instr_valid}, 32'd0);
        chk("req_rise", {31'd0, imem_req}, 32'd1);
        chk("count", instr_count, exp_count);
    endtask

    function automatic logic [31:0] word_for(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    initial begin
        rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = 32'd0; stall = 1'b1;
        pcSrcCtrl = 2'd0; jAddr = 26'd0; imm = 32'd0; jrTarget = 32'd0;
        aluZero = 1'b0; bneCtrl = 1'b0; exp_count = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_count", instr_count, 32'd0);
        chk("rst_pc", imem_addr, 32'h0000_0100);
        rst_n = 1'b1;
        exp_addr_q.push_back(32'h0000_0100);

        // First fetch, ack after 2 cycles; stall rises with valid.
        fetch(2, 32'h8C01_0004);
        chk("count0", instr_count, 32'd0);
        // Stall 3 cycles with stray acks that must be ignored.
        for (int i = 0; i < 3; i++) begin
            imem_ack = 1'b1; imem_rdata = 32'hFFFF_FFFF;
            @(negedge clk);
            chk("stall_instr", instr, 32'h8C01_0004);
            chk("stall_valid", {31'd0, instr_valid}, 32'd1);
            chk("stall_req", {31'd0, imem_req}, 32'd0);
            chk("stall_count", instr_count, 32'd0);
        end
        imem_ack = 1'b0;
        accept(2'd0, 26'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'h0000_0104);

        fetch(1, word_for(32'h104));
        accept(2'd2, 26'd0, 32'd0, 32'h1000_0003, 1'b0, 1'b0, 32'h1000_0000);
        fetch(3, word_for(32'h1000_0000));
        accept(2'd1, 26'h0000040, 32'd0, 32'd0, 1'b0, 1'b0, 32'h1000_0100);
        fetch(1, word_for(32'h1000_0100));
        accept(2'd2, 26'd0, 32'd0, 32'h0000_2003, 1'b0, 1'b0, 32'h0000_2000);
        fetch(2, word_for(32'h2000));
        accept(2'd2, 26'd0, 32'd0, 32'h0000_0200, 1'b0, 1'b0, 32'h0000_0200);
        // Branches from 0x200 with imm = -2.
        fetch(1, word_for(32'h200));
        accept(2'd3, 26'd0, 32'hFFFF_FFFE, 32'd0, 1'b1, 1'b0, 32'h0000_01FC);
        fetch(1, word_for(32'h1FC));
        accept(2'd2, 26'd0, 32'd0, 32'h0000_0200, 1'b0, 1'b0, 32'h0000_0200);
        fetch(1, word_for(32'h200));
        accept(2'd3, 26'd0, 32'hFFFF_FFFE, 32'd0, 1'b1, 1'b1, 32'h0000_0204);
        fetch(1, word_for(32'h204));
        accept(2'd2, 26'd0, 32'd0, 32'h0000_0200, 1'b0, 1'b0, 32'h0000_0200);
        fetch(1, word_for(32'h200));
        accept(2'd3, 26'd0, 32'hFFFF_FFFE, 32'd0, 1'b0, 1'b1, 32'h0000_01FC);
        fetch(1, word_for(32'h1FC));
        accept(2'd2, 26'd0, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'hFFFF_FFFC);
        // PC wrap plus counter wrap on the same accept.
        fetch(2, word_for(32'hFFFF_FFFC));
        force dut.count_r = 32'hFFFF_FFFF;
        #1;
        release dut.count_r;
        chk("count_preload", instr_count, 32'hFFFF_FFFF);
        exp_count = 32'hFFFF_FFFF;
        accept(2'd0, 26'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'h0000_0000);

        // Reset in the middle of a request, then a late ack after release.
        wait_req();
        rst_n = 1'b0;
        #1;
        chk("midrst_req", {31'd0, imem_req}, 32'd0);
        chk("midrst_valid", {31'd0, instr_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        imem_ack = 1'b0;
        chk("late_ack_valid", {31'd0, instr_valid}, 32'd0);
        chk("late_ack_instr", instr, 32'd0);
        exp_count = 32'd0;
        exp_addr_q.push_back(32'h0000_0100);
        fetch(1, 32'h1234_5678);
        chk("count_after_rst", instr_count, exp_count);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
